// File: rtl/result_collector.sv
// Collects one n x n matrix of 32-bit results in row-major order, then hands it
// to a file writer through a level start / done handshake with random-access reads.
module result_collector #(
  parameter int n = 4,
  localparam int IW = $clog2(n) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_start,
  input  logic [IW-1:0] wr_i,
  input  logic [IW-1:0] wr_j,
  output logic [31:0]   wr_value,
  input  logic          wr_done,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Array index width; the extra counter bit in IW only serves range checks.
  localparam int AW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] row_reg, row_next;
  logic [IW-1:0] col_reg, col_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          accept;
  logic          last_elem;
  logic          col_end;

  // Result storage has no reset so contents survive frames and reset.
  logic [31:0] mem [n][n];

  assign accept    = in_valid && (state_reg == FILL);
  assign col_end   = (col_reg == IW'(n - 1));
  assign last_elem = (row_reg == IW'(n - 1)) && col_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    case (state_reg)
      IDLE: state_next = FILL;
      FILL: begin
        if (accept) begin
          // Framing is judged purely by element count; the frame always completes.
          if (in_last != last_elem) begin
            err_next = 1'b1;
          end
          if (last_elem) begin
            row_next   = '0;
            col_next   = '0;
            state_next = WRITE;
          end else if (col_end) begin
            col_next = '0;
            row_next = row_reg + IW'(1);
          end else begin
            col_next = col_reg + IW'(1);
          end
        end
      end
      WRITE: begin
        if (wr_done) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!wr_done) begin
          state_next = FILL;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[row_reg[AW-1:0]][col_reg[AW-1:0]] <= in_data;
    end
  end

  // Out-of-range writer indices read as zero rather than aliasing into the array.
  always_comb begin
    wr_value = '0;
    if ((wr_i < IW'(n)) && (wr_j < IW'(n))) begin
      wr_value = mem[wr_i[AW-1:0]][wr_j[AW-1:0]];
    end
  end

  assign in_ready = (state_reg == FILL);
  assign wr_start = (state_reg == WRITE);
  assign busy     = (state_reg == WRITE) || (state_reg == RELEASE);
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: a frame-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_result_collector;
  localparam int N  = 4;
  localparam int IW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          wr_start;
  logic [IW-1:0] wr_i = '0;
  logic [IW-1:0] wr_j = '0;
  logic [31:0]   wr_value;
  logic          wr_done = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  result_collector #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .wr_start(wr_start),
    .wr_i(wr_i), .wr_j(wr_j), .wr_value(wr_value), .wr_done(wr_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: stage 0 just after reset, 1 collecting, 2 waiting for
  // the writer to finish, 3 waiting for the writer to let go of wr_done.
  int   m_stage = 0;
  int   m_count = 0;
  bit   m_done  = 1'b0;
  bit   m_err   = 1'b0;
  int   m_mem [N*N];
  bit   m_known [N*N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage = 0;
      m_count = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_stage)
        0: m_stage = 1;
        1: if (in_valid) begin
          m_mem[m_count]   = in_data;
          m_known[m_count] = 1'b1;
          if (in_last != (m_count == N*N - 1)) m_err = 1'b1;
          m_count++;
          if (m_count == N*N) begin
            m_count = 0;
            m_stage = 2;
          end
        end
        2: if (wr_done) m_stage = 3;
        default: if (!wr_done) begin
          m_stage = 1;
          m_done  = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int idx;
    check("in_ready", in_ready, m_stage == 1);
    check("wr_start", wr_start, m_stage == 2);
    check("busy", busy, m_stage >= 2);
    check("done", done, m_done);
    check("err", err, m_err);
    if (wr_i < N && wr_j < N) begin
      idx = int'(wr_i) * N + int'(wr_j);
      if (m_known[idx]) check("wr_value", wr_value, m_mem[idx]);
    end else begin
      check("wr_value_oob", wr_value, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
  endtask

  task automatic read_at(input int i, input int j, input logic [31:0] exp, input string name);
    wr_i = IW'(i);
    wr_j = IW'(j);
    #1;
    check(name, wr_value, exp);
  endtask

  task automatic handshake(input int hi_cycles);
    in_valid = 1'b0;
    wr_done  = 1'b1;
    repeat (hi_cycles) tick();
    wr_done = 1'b0;
    tick();
    check("hs_done", done, 1);
    tick();
  endtask

  initial begin
    for (int k = 0; k < N*N; k++) m_known[k] = 1'b0;
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_start", wr_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);
    check("rel_busy", busy, 0);

    // Frame 1: 1..16 back to back.
    for (int k = 1; k <= 16; k++) beat(k, k == 16);
    check("f1_wr_start", wr_start, 1);
    check("f1_in_ready", in_ready, 0);
    check("f1_busy", busy, 1);
    read_at(2, 3, 12, "f1_rd23");
    read_at(0, 0, 1, "f1_rd00");
    read_at(4, 0, 0, "f1_rd40");
    // Traffic during WRITE must be ignored.
    in_valid = 1'b1; in_data = 999; in_last = 1'b1;
    repeat (3) tick();
    check("f1_hold_start", wr_start, 1);
    read_at(0, 0, 1, "f1_hold_rd00");
    check("f1_hold_err", err, 0);
    in_valid = 1'b0;
    wr_done  = 1'b1;
    tick();
    check("hs_start_drop", wr_start, 0);
    check("hs_no_done1", done, 0);
    tick();
    check("hs_no_done2", done, 0);
    tick();
    check("hs_no_done3", done, 0);
    wr_done = 1'b0;
    tick();
    check("hs_done_pulse", done, 1);
    check("hs_in_ready", in_ready, 1);
    tick();
    check("hs_done_clear", done, 0);
    $display("frame 1 collected and released");

    // Frame 2: 201..216 with random idle gaps.
    for (int k = 1; k <= 16; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; in_data = 32'hdead; in_last = 1'b1;
        tick();
      end
      beat(200 + k, k == 16);
    end
    in_valid = 1'b0;
    check("f2_wr_start", wr_start, 1);
    read_at(1, 2, 207, "f2_rd12");
    handshake(1);
    $display("frame 2 collected with gaps");

    // Frame 3: premature in_last on element 5.
    for (int k = 1; k <= 16; k++) begin
      beat(300 + k, k == 5);
      if (k == 4) check("f3_err_pre", err, 0);
      if (k == 5) check("f3_err_set", err, 1);
      if (k == 15) check("f3_no_start", wr_start, 0);
    end
    in_valid = 1'b0;
    check("f3_wr_start", wr_start, 1);
    handshake(2);
    $display("frame 3 collected with framing error");

    // Frame 4: clean, error stays sticky.
    for (int k = 1; k <= 16; k++) beat(400 + k, k == 16);
    in_valid = 1'b0;
    check("f4_err_sticky", err, 1);
    read_at(3, 3, 416, "f4_rd33");
    handshake(1);
    $display("frame 4 collected, error sticky");

    // Reset after 7 accepts, then a full frame of 101..116.
    for (int k = 1; k <= 7; k++) beat(500 + k, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      beat(100 + k, k == 16);
      if (k == 15) check("f5_no_start", wr_start, 0);
    end
    in_valid = 1'b0;
    check("f5_wr_start", wr_start, 1);
    read_at(0, 0, 101, "f5_rd00");
    read_at(3, 3, 116, "f5_rd33");
    check("f5_err", err, 0);
    handshake(1);
    $display("frame 5 collected after mid-fill reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
